bit_timer_rx: RTL and testbench
===============================

// Module: bit_timer_rx
// PURPOSE
//  Parametrised successor of the USB RX bit-period counter. Tracks bit timing per packet for the receiver.
//  - Full- and low-speed modes.
//  - Edge resynchronisation (DPLL-lite).
//  - Mid-bit sample strobe; bit-stuff-aware bit/byte counting.
//  Sits between the D+/D- edge detector and the NRZI decoder / shift register.
// PARAMETERS
//  FS_CLKS_PER_BIT  4  clk cycles per full-speed bit; even, >=4 (48 MHz / 12 Mbps)
//  LS_DIV           8  low-speed period multiplier (P_LS = FS_CLKS_PER_BIT*LS_DIV)
//  BITS_PER_BYTE    8  bits per byte_done pulse
//  DRIFT_TOL        1  resync window half-width in clks (drift monitor only)
//  localparam CNT_W = $clog2(FS_CLKS_PER_BIT*LS_DIV)
// PORTS
//  clk          in   1                    system clock
//  rst          in   1                    synchronous reset, active-high
//  enable       in   1                    packet receive active; rises aligned to first SYNC edge
//  low_speed    in   1                    1 = LS period; latched on IDLE->RUN only
//  edge_det     in   1                    1-cycle pulse, synchronised D+/D- transition
//  stuff_skip   in   1                    current strobed bit is a stuffed bit
//  sample_strobe out 1                    mid-bit sample point, every bit
//  shift_en     out  1                    sample_strobe & ~stuff_skip
//  byte_done    out  1                    pulses with shift_en of last bit of a byte
//  bit_cnt      out  $clog2(BITS_PER_BYTE) data bits received in current byte
//  drift_err    out  1                    edge outside tolerance window (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; cnt=0; bit_cnt=0; all outputs 0.
//  - rst overrides all inputs.
//  - P = low_speed_q ? FS_CLKS_PER_BIT*LS_DIV : FS_CLKS_PER_BIT; HALF = P/2.
//  - IDLE: cnt=0, bit_cnt=0, strobes 0.
//    - enable=1 -> RUN next cycle with cnt=0; low_speed_q <= low_speed in the same cycle.
//  - RUN, per cycle, priority order:
//    1. enable=0 -> IDLE next cycle; cnt and bit_cnt cleared (mid-byte abort, no byte_done).
//    2. edge_det=1 -> cnt_next=1 (edge cycle treated as bit position 0).
//    3. else cnt_next = (cnt==P-1) ? 0 : cnt+1 (wrap).
//  - sample_strobe = (state==RUN && cnt==HALF); combinational decode of registered state, glitch-free.
//    - An edge in the strobe cycle does not cancel that strobe.
//  - shift_en = sample_strobe & ~stuff_skip; stuffed bits never counted.
//  - On shift_en: bit_cnt <= (bit_cnt==BITS_PER_BYTE-1) ? 0 : bit_cnt+1.
//  - byte_done = shift_en && bit_cnt==BITS_PER_BYTE-1 (same cycle as the 8th shift_en).
//  - low_speed changes during RUN are ignored until the next IDLE->RUN.
//  - Latency: first strobe HALF+1 cycles after the enable-rise cycle.
//  - Period: P cycles between strobes absent edges.
// CONFIGURATION
//  - Macro BIT_TIMER_DRIFT_MON_EN defined:
//    - drift_err pulses 1 cycle, same cycle as edge_det in RUN, when cnt is outside [P-DRIFT_TOL, P-1] U [0, DRIFT_TOL].
//    - Resync still applied.
//  - Macro undefined: drift_err tied 0; no monitor logic; port list unchanged.
// TESTING (FS_CLKS_PER_BIT=4, LS_DIV=8, DRIFT_TOL=1)
//  - Reset: rst=1 for 2 clks during RUN -> state IDLE, bit_cnt=0, all strobes 0 next cycle.
//  - FS free-run: enable rises cycle 0, no edges -> sample_strobe cycles 3,7,11,...; byte_done cycle 31, bit_cnt back to 0.
//  - Resync: edge_det when cnt==3 -> cnt=1 next; strobe 1 cycle later; next strobe 4 cycles after that.
//  - LS: low_speed=1 at enable rise -> strobe cycle 17 then every 32; toggling low_speed mid-packet changes nothing.
//  - Stuffing: stuff_skip=1 on 3rd strobe -> shift_en absent there, bit_cnt holds, byte_done on 9th strobe.
//  - Abort + drift (macro on): edge at cnt==2 -> drift_err=1 that cycle. enable=0 at bit_cnt=5 -> IDLE next cycle, bit_cnt=0, no byte_done.

Source files
------------

// File: rtl/bit_timer_rx.sv
// USB receive bit-period timer: mid-bit sample strobe, edge resync, stuff-aware bit/byte counting.
// Optional drift monitor on drift_err is built only when BIT_TIMER_DRIFT_MON_EN is defined.
module bit_timer_rx #(
  parameter int FS_CLKS_PER_BIT = 4,
  parameter int LS_DIV          = 8,
  parameter int BITS_PER_BYTE   = 8,
  parameter int DRIFT_TOL       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             low_speed,
  input  logic                             edge_det,
  input  logic                             stuff_skip,
  output logic                             sample_strobe,
  output logic                             shift_en,
  output logic                             byte_done,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt,
  output logic                             drift_err
);

  localparam int P_FS  = FS_CLKS_PER_BIT;
  localparam int P_LS  = FS_CLKS_PER_BIT * LS_DIV;
  localparam int CNT_W = $clog2(P_LS);
  localparam int BC_W  = $clog2(BITS_PER_BYTE);

  localparam logic [CNT_W-1:0] FS_LAST = CNT_W'(P_FS - 1);
  localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(P_LS - 1);
  localparam logic [CNT_W-1:0] FS_HALF = CNT_W'(P_FS / 2);
  localparam logic [CNT_W-1:0] LS_HALF = CNT_W'(P_LS / 2);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BITS_PER_BYTE - 1);

  // Reject configurations where the strobe could not sit mid-bit or the window would swallow it.
  if (FS_CLKS_PER_BIT < 4 || (FS_CLKS_PER_BIT % 2) != 0) begin : g_bad_fs
    $error("bit_timer_rx: FS_CLKS_PER_BIT must be even and >= 4");
  end
  if (LS_DIV < 1) begin : g_bad_ls
    $error("bit_timer_rx: LS_DIV must be >= 1");
  end
  if (BITS_PER_BYTE < 2) begin : g_bad_bpb
    $error("bit_timer_rx: BITS_PER_BYTE must be >= 2");
  end
  if (DRIFT_TOL < 0 || DRIFT_TOL >= FS_CLKS_PER_BIT / 2) begin : g_bad_tol
    $error("bit_timer_rx: DRIFT_TOL must lie in [0, FS_CLKS_PER_BIT/2)");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [BC_W-1:0]  w_bit_cnt_next;
  logic             r_low_speed;
  logic             w_low_speed_next;

  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_half;
  logic             w_strobe;
  logic             w_shift;
  logic             w_byte_last;

  // Period is frozen for the whole packet by the speed captured at IDLE->RUN.
  assign w_last = r_low_speed ? LS_LAST : FS_LAST;
  assign w_half = r_low_speed ? LS_HALF : FS_HALF;

  // Strobes decode registered state only, so they cannot glitch and an edge cannot cancel them.
  assign w_strobe    = (r_state == ST_RUN) && (r_cnt == w_half);
  assign w_shift     = w_strobe && !stuff_skip;
  assign w_byte_last = (r_bit_cnt == BC_LAST);

  assign sample_strobe = w_strobe;
  assign shift_en      = w_shift;
  assign byte_done     = w_shift && w_byte_last;
  assign bit_cnt       = r_bit_cnt;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_low_speed <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_low_speed <= w_low_speed_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_low_speed_next = r_low_speed;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next     = '0;
        w_bit_cnt_next = '0;
        if (enable) begin
          w_state_next     = ST_RUN;
          w_low_speed_next = low_speed;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Abort mid-byte: partial byte is discarded, nothing signalled downstream.
          w_state_next   = ST_IDLE;
          w_cnt_next     = '0;
          w_bit_cnt_next = '0;
        end else begin
          if (edge_det) begin
            // The edge cycle itself is bit position 0, so the next count is 1.
            w_cnt_next = CNT_W'(1);
          end else if (r_cnt == w_last) begin
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end

          if (w_shift) begin
            w_bit_cnt_next = w_byte_last ? '0 : r_bit_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifdef BIT_TIMER_DRIFT_MON_EN
  // Edges are expected within DRIFT_TOL of the bit boundary; anything else is flagged but still resyncs.
  localparam logic [CNT_W-1:0] FS_WIN_LO = CNT_W'(P_FS - DRIFT_TOL);
  localparam logic [CNT_W-1:0] LS_WIN_LO = CNT_W'(P_LS - DRIFT_TOL);
  localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(DRIFT_TOL);

  logic [CNT_W-1:0] w_win_lo;
  logic             w_in_window;

  assign w_win_lo    = r_low_speed ? LS_WIN_LO : FS_WIN_LO;
  assign w_in_window = (r_cnt >= w_win_lo) || (r_cnt <= WIN_HI);
  assign drift_err   = (r_state == ST_RUN) && edge_det && !w_in_window;
`else
  assign drift_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_timer_rx.sv
// Directed self-checking bench for bit_timer_rx (FS=4 clk/bit, LS_DIV=8, DRIFT_TOL=1).
// Each cycle compares {sample_strobe, shift_en, byte_done, drift_err, bit_cnt} against hand-derived values.
module tb_bit_timer_rx;

  localparam int FS_CLKS_PER_BIT = 4;
  localparam int LS_DIV          = 8;
  localparam int BITS_PER_BYTE   = 8;
  localparam int DRIFT_TOL       = 1;

`ifdef BIT_TIMER_DRIFT_MON_EN
  localparam bit DRIFT_ON = 1'b1;
`else
  localparam bit DRIFT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       low_speed;
  logic       edge_det;
  logic       stuff_skip;
  logic       sample_strobe;
  logic       shift_en;
  logic       byte_done;
  logic [2:0] bit_cnt;
  logic       drift_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit_timer_rx #(
    .FS_CLKS_PER_BIT(FS_CLKS_PER_BIT),
    .LS_DIV         (LS_DIV),
    .BITS_PER_BYTE  (BITS_PER_BYTE),
    .DRIFT_TOL      (DRIFT_TOL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .low_speed    (low_speed),
    .edge_det     (edge_det),
    .stuff_skip   (stuff_skip),
    .sample_strobe(sample_strobe),
    .shift_en     (shift_en),
    .byte_done    (byte_done),
    .bit_cnt      (bit_cnt),
    .drift_err    (drift_err)
  );

  always #5 clk = ~clk;

  // Cycle n: inputs applied just after a falling edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_gap();
    rst        = 1'b0;
    enable     = 1'b0;
    low_speed  = 1'b0;
    edge_det   = 1'b0;
    stuff_skip = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [6:0] obs, exp_v;
    logic [2:0] e_bits;
    logic       e_strb;
    for (int i = 0; i < 2; i++) begin
      #1;
      obs = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_hold i=%0d got %b required %b", i, obs, 7'b0);
      end
      step();
    end
    // Packet runs, then rst held 2 clks during RUN with enable still high.
    rst    = 1'b0;
    e_bits = 3'd0;
    for (int c = 0; c < 20; c++) begin
      enable = 1'b1;
      rst    = (c == 13) || (c == 14);
      #1;
      e_strb = (c == 3) || (c == 7) || (c == 11) || (c == 18);
      exp_v  = {e_strb, e_strb, 1'b0, 1'b0, e_bits};
      obs    = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_in_run c=%0d got strb/shf/byte/drift/bits=%b required %b", c, obs, exp_v);
      end
      step();
      if (c == 13 || c == 14) e_bits = 3'd0;
      else if (e_strb)        e_bits = e_bits + 3'd1;
    end
  endtask

  task automatic test_fs_free_run();
    logic [6:0] obs, exp_v;
    logic [2:0] e_bits;
    logic       e_strb;
    e_bits = 3'd0;
    for (int c = 0; c < 36; c++) begin
      enable = 1'b1;
      #1;
      e_strb = (c >= 3) && (((c - 3) % 4) == 0);
      exp_v  = {e_strb, e_strb, (c == 31), 1'b0, e_bits};
      obs    = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL fs_free_run c=%0d got strb/shf/byte/drift/bits=%b required %b", c, obs, exp_v);
      end
      step();
      if (e_strb) e_bits = e_bits + 3'd1;
    end
  endtask

  task automatic test_resync();
    logic [6:0] obs, exp_v;
    logic [2:0] e_bits;
    logic       e_strb;
    logic       e_drift;
    e_bits = 3'd0;
    for (int c = 0; c < 27; c++) begin
      enable   = 1'b1;
      edge_det = (c == 8) || (c == 14);
      #1;
      e_strb  = (c == 3) || (c == 7) || (c == 10) || (c == 14) ||
                (c == 16) || (c == 20) || (c == 24);
      e_drift = DRIFT_ON && (c == 14);
      exp_v   = {e_strb, e_strb, 1'b0, e_drift, e_bits};
      obs     = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL resync c=%0d got strb/shf/byte/drift/bits=%b required %b", c, obs, exp_v);
      end
      step();
      if (e_strb) e_bits = e_bits + 3'd1;
    end
    edge_det = 1'b0;
  endtask

  task automatic test_low_speed();
    logic [6:0] obs, exp_v;
    logic [2:0] e_bits;
    logic       e_strb;
    e_bits = 3'd0;
    for (int c = 0; c < 86; c++) begin
      enable    = 1'b1;
      low_speed = ((c % 10) < 5);
      #1;
      e_strb = (c >= 17) && (((c - 17) % 32) == 0);
      exp_v  = {e_strb, e_strb, 1'b0, 1'b0, e_bits};
      obs    = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL low_speed c=%0d got strb/shf/byte/drift/bits=%b required %b", c, obs, exp_v);
      end
      step();
      if (e_strb) e_bits = e_bits + 3'd1;
    end
  endtask

  task automatic test_stuffing();
    logic [6:0] obs, exp_v;
    logic [2:0] e_bits;
    logic       e_strb;
    logic       e_shift;
    e_bits = 3'd0;
    for (int c = 0; c < 38; c++) begin
      enable     = 1'b1;
      stuff_skip = (c == 11) || (c == 13);
      #1;
      e_strb  = (c >= 3) && (((c - 3) % 4) == 0);
      e_shift = e_strb && (c != 11);
      exp_v   = {e_strb, e_shift, (c == 35), 1'b0, e_bits};
      obs     = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stuffing c=%0d got strb/shf/byte/drift/bits=%b required %b", c, obs, exp_v);
      end
      step();
      if (e_shift) e_bits = e_bits + 3'd1;
    end
    stuff_skip = 1'b0;
  endtask

  task automatic test_abort_drift();
    logic [6:0] obs, exp_v;
    logic [2:0] e_bits;
    logic       e_strb;
    logic       e_drift;
    e_bits = 3'd0;
    for (int c = 0; c < 28; c++) begin
      enable   = (c < 19);
      edge_det = (c == 3);
      #1;
      e_strb  = (c == 3) || (c == 5) || (c == 9) || (c == 13) || (c == 17);
      e_drift = DRIFT_ON && (c == 3);
      exp_v   = {e_strb, e_strb, 1'b0, e_drift, e_bits};
      obs     = {sample_strobe, shift_en, byte_done, drift_err, bit_cnt};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL abort_drift c=%0d got strb/shf/byte/drift/bits=%b required %b", c, obs, exp_v);
      end
      step();
      if (c == 19)     e_bits = 3'd0;
      else if (e_strb) e_bits = e_bits + 3'd1;
    end
    edge_det = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    low_speed  = 1'b0;
    edge_det   = 1'b0;
    stuff_skip = 1'b0;
    @(negedge clk);

    test_reset();
    idle_gap();
    test_fs_free_run();
    idle_gap();
    test_resync();
    idle_gap();
    test_low_speed();
    idle_gap();
    test_stuffing();
    idle_gap();
    test_abort_drift();
    idle_gap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
